alert_monitor: RTL and testbench
================================

Name: alert_monitor

Overview:
- Condition monitor directly upstream of the piezo driver.
- Turns raw battery ADC samples and left/right wheel speed samples into the clean, level-type too_fast and batt_low flags that the piezo driver consumes.
- Averages battery readings and applies hysteresis so batt_low does not chatter near the threshold.
- Debounces overspeed so a single noisy speed sample cannot trigger the alarm.

Parameters:
- AVG_LOG2, 2: log2 of the number of battery samples per average (4 samples).
- BATT_THRES, 12'h800: batt_low asserts when the average falls below this value.
- BATT_HYST, 12'h040: batt_low clears only when the average is >= BATT_THRES+BATT_HYST.
- FAST_THRES, 12'd1536: overspeed magnitude threshold; the comparison is strictly greater than.
- FAST_CNT, 4: number of consecutive overspeed samples needed to assert too_fast (range 1..15).

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: reset, asynchronous, active-low.
- batt_vld, input, 1: one-cycle strobe, batt is valid.
- batt, input, 12: unsigned battery ADC reading.
- spd_vld, input, 1: one-cycle strobe, lft_spd/rght_spd are valid.
- lft_spd, input, 12: signed left wheel speed.
- rght_spd, input, 12: signed right wheel speed.
- pwr_up, input, 1: rider on and system balancing; low suppresses the speed alarm.
- batt_avg, output, 12: most recent completed battery average.
- batt_low, output, 1: battery-low level flag to the piezo driver.
- too_fast, output, 1: overspeed level flag to the piezo driver.

Behaviour:

Reset:
- rst_n low clears all registers asynchronously: batt_avg=0, batt_low=0, too_fast=0, accumulator=0, sample count=0, fast_cnt=0, battery FSM=INIT.
- Reset mid-average discards the partial accumulation.

Battery accumulator:
- Accumulator width is 12+AVG_LOG2; sample counter width is AVG_LOG2.
- On each batt_vld: acc <= acc+batt, cnt <= cnt+1 (wraps).
- On the batt_vld where cnt == 2^AVG_LOG2-1 (last sample), at the same edge:
  - batt_avg <= (acc+batt)>>AVG_LOG2, truncated;
  - acc <= 0, cnt wraps to 0;
  - the battery FSM evaluates the new average, called new_avg below.
- Update latency: batt_avg and batt_low change on the edge that accepts the last sample.
- No overflow is possible: the sum of 2^AVG_LOG2 twelve-bit values fits the accumulator width.

Battery FSM (states INIT, OK, LOW):
- INIT: batt_low=0. On the first completed average, go to LOW if new_avg < BATT_THRES, else go to OK.
- OK: batt_low=0. Go to LOW when new_avg < BATT_THRES.
- LOW: batt_low=1. Go to OK only when new_avg >= BATT_THRES+BATT_HYST. Compute this sum at 13 bits; no wrap.
- Averages falling in the hysteresis band leave the state unchanged.
- batt_low is a registered Moore output (LOW state). It updates at the same edge as batt_avg, on the last sample's edge as stated above.

Speed path:
- sum = sign-extended lft_spd + rght_spd (13-bit signed); avg = sum>>>1, arithmetic shift.
- mag = |avg|, 12-bit unsigned. The maximum is 2048 for -2048+-2048; saturate this to 2047.
- On each spd_vld with pwr_up=1:
  - if mag > FAST_THRES: fast_cnt <= min(fast_cnt+1, FAST_CNT);
  - else: fast_cnt <= 0.
- fast_cnt is 4 bits wide and saturates at FAST_CNT; it never wraps.
- too_fast is registered:
  - set at the edge that accepts the FAST_CNT-th consecutive overspeed sample;
  - cleared at the edge that accepts the first sample with mag <= FAST_THRES;
  - holds between spd_vld strobes.
- pwr_up=0: fast_cnt <= 0 and too_fast <= 0 every cycle, regardless of spd_vld.

Independence and event handling:
- The battery and speed paths are fully independent; simultaneous batt_vld and spd_vld are each processed in the same cycle.
- Back-to-back strobes on consecutive cycles are each accepted.
- Inputs are ignored whenever their vld strobe is low.

Test Plan:
1. Four batt_vld samples of 12'h900 after reset -> batt_avg=12'h900, batt_low=0, FSM OK; batt_avg and batt_low stay at 0 before the 4th sample.
2. From OK: 4 samples of 12'h7F0 -> batt_low=1 on the 4th sample's edge. Then 4 samples of 12'h820 -> batt_low stays 1 (in band). Then 4 samples of 12'h840 -> batt_low=0.
3. pwr_up=1, lft_spd=rght_spd=1600 for 3 spd_vld -> too_fast=0. 4th sample -> too_fast=1. Next sample with lft=rght=1536 -> too_fast=0 (equality is not over).
4. Overspeed pattern of 3 samples at 1600, 1 at 100, 3 at 1600 -> too_fast never asserts. Also lft=-2048, rght=-2048 for 4 samples -> mag saturates to 2047, too_fast=1.
5. too_fast=1, then pwr_up=0 -> too_fast=0 next edge, fast_cnt=0. Then pwr_up=1 -> 4 fresh overspeed samples required to reassert.
6. Assert rst_n low after 2 of 4 battery samples while too_fast=1 -> all outputs 0 immediately. After release, 4 new samples of 12'h600 -> batt_avg=12'h600, batt_low=1 (INIT->LOW).

Source files
------------

// File: rtl/alert_monitor.sv
// -----------------------------------------------------------------------------
// alert_monitor
//   Condition monitor feeding the piezo driver. Averages battery ADC readings
//   in blocks of 2^AVG_LOG2 samples and applies hysteresis to produce batt_low.
//   Averages the left/right wheel speeds and debounces overspeed over FAST_CNT
//   consecutive samples to produce too_fast.
//
// Ports
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset
//   batt_vld  in   one-cycle strobe, batt valid
//   batt      in   [11:0] unsigned battery ADC reading
//   spd_vld   in   one-cycle strobe, lft_spd/rght_spd valid
//   lft_spd   in   [11:0] signed left wheel speed
//   rght_spd  in   [11:0] signed right wheel speed
//   pwr_up    in   rider on / balancing; low suppresses the speed alarm
//   batt_avg  out  [11:0] most recent completed battery average
//   batt_low  out  battery-low level flag
//   too_fast  out  overspeed level flag
// -----------------------------------------------------------------------------
module alert_monitor #(
   parameter int unsigned AVG_LOG2   = 2,
   parameter logic [11:0] BATT_THRES = 12'h800,
   parameter logic [11:0] BATT_HYST  = 12'h040,
   parameter logic [11:0] FAST_THRES = 12'd1536,
   parameter int unsigned FAST_CNT   = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        batt_vld,
   input  logic [11:0] batt,
   input  logic        spd_vld,
   input  logic [11:0] lft_spd,
   input  logic [11:0] rght_spd,
   input  logic        pwr_up,
   output logic [11:0] batt_avg,
   output logic        batt_low,
   output logic        too_fast
);

   localparam int unsigned ACC_W     = 12 + AVG_LOG2;
   // Clear threshold computed one bit wider so the sum cannot wrap.
   localparam logic [12:0] CLR_THRES = {1'b0, BATT_THRES} + {1'b0, BATT_HYST};
   localparam logic [3:0]  FAST_MAX  = 4'(FAST_CNT);

   typedef enum logic [1:0] {INIT, OK, LOW} batt_state_t;

   // |v| of a 13-bit signed value, saturated to the 12-bit unsigned range.
   // Only -2048 + -2048 (halved to -2048) reaches 2048.
   function automatic logic [11:0] sat_mag(input logic signed [12:0] v);
      logic signed [12:0] a;
      a = v[12] ? -v : v;
      if (a > 13'sd2047) return 12'd2047;
      return a[11:0];
   endfunction

   // ---------------- battery accumulator ----------------
   logic [ACC_W-1:0]    acc;
   logic [ACC_W-1:0]    acc_sum;
   logic [AVG_LOG2-1:0] cnt;
   logic                last;
   logic                avg_done;
   logic [11:0]         new_avg;
   batt_state_t         state;
   batt_state_t         state_nxt;

   assign acc_sum  = acc + ACC_W'(batt);
   assign last     = (cnt == {AVG_LOG2{1'b1}});
   assign avg_done = batt_vld & last;
   assign new_avg  = acc_sum[ACC_W-1:AVG_LOG2];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc      <= '0;
         cnt      <= '0;
         batt_avg <= '0;
      end else if (batt_vld) begin
         cnt <= cnt + AVG_LOG2'(1);
         if (last) begin
            acc      <= '0;
            batt_avg <= new_avg;
         end else begin
            acc <= acc_sum;
         end
      end
   end

   // ---------------- battery hysteresis FSM ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= INIT;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (avg_done) begin
         case (state)
            INIT:    state_nxt = (new_avg < BATT_THRES) ? LOW : OK;
            OK:      if (new_avg < BATT_THRES) state_nxt = LOW;
            LOW:     if ({1'b0, new_avg} >= CLR_THRES) state_nxt = OK;
            default: state_nxt = INIT;
         endcase
      end
   end

   assign batt_low = (state == LOW);

   // ---------------- speed path ----------------
   logic signed [12:0] spd_sum;
   logic signed [12:0] spd_half;
   logic [11:0]        spd_mag;
   logic               over;
   logic [3:0]         fast_cnt;
   logic [3:0]         fast_cnt_nxt;

   assign spd_sum  = {lft_spd[11], lft_spd} + {rght_spd[11], rght_spd};
   assign spd_half = spd_sum >>> 1;
   assign spd_mag  = sat_mag(spd_half);
   assign over     = (spd_mag > FAST_THRES);

   // Saturating run-length of consecutive overspeed samples.
   always_comb begin
      fast_cnt_nxt = '0;
      if (over) fast_cnt_nxt = (fast_cnt >= FAST_MAX) ? FAST_MAX : fast_cnt + 4'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fast_cnt <= '0;
         too_fast <= 1'b0;
      end else if (!pwr_up) begin
         fast_cnt <= '0;
         too_fast <= 1'b0;
      end else if (spd_vld) begin
         fast_cnt <= fast_cnt_nxt;
         too_fast <= (fast_cnt_nxt == FAST_MAX);
      end
   end

endmodule

// File: tb/tb_alert_monitor.sv
// -----------------------------------------------------------------------------
// tb_alert_monitor
//   Directed and randomized stimulus for alert_monitor, checked against a
//   behavioural model: a list of pending battery samples averaged with plain
//   integer arithmetic, a low/not-low flag with hysteresis, and an integer
//   overspeed streak length.
// -----------------------------------------------------------------------------
module tb_alert_monitor;

   localparam int THRES = 2048;
   localparam int CLR   = 2048 + 64;
   localparam int FTHR  = 1536;
   localparam int FCNT  = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        batt_vld;
   logic [11:0] batt;
   logic        spd_vld;
   logic [11:0] lft_spd;
   logic [11:0] rght_spd;
   logic        pwr_up;
   logic [11:0] batt_avg;
   logic        batt_low;
   logic        too_fast;

   int total = 0;
   int bad   = 0;

   // model state
   int q_batt[$];
   int m_avg    = 0;
   bit m_low    = 1'b0;
   int m_streak = 0;

   alert_monitor dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .batt_vld (batt_vld),
      .batt     (batt),
      .spd_vld  (spd_vld),
      .lft_spd  (lft_spd),
      .rght_spd (rght_spd),
      .pwr_up   (pwr_up),
      .batt_avg (batt_avg),
      .batt_low (batt_low),
      .too_fast (too_fast)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int act, input int exp);
      total++;
      assert (act === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, act, exp);
      end
   endtask

   task automatic chk_all(input string tag);
      chk({tag, ".batt_avg"}, int'(batt_avg), m_avg);
      chk({tag, ".batt_low"}, int'(batt_low), int'(m_low));
      chk({tag, ".too_fast"}, int'(too_fast), int'(m_streak >= FCNT));
   endtask

   task automatic model_reset();
      q_batt.delete();
      m_avg    = 0;
      m_low    = 1'b0;
      m_streak = 0;
   endtask

   // One clock cycle with the given strobes; model updated at the edge.
   task automatic step(input string tag, input bit bv, input int b,
                       input bit sv, input int l, input int r);
      int sum;
      int avg;
      int mag;
      @(negedge clk);
      batt_vld = bv;
      batt     = 12'(b);
      spd_vld  = sv;
      lft_spd  = 12'(l);
      rght_spd = 12'(r);
      @(posedge clk);
      if (bv) begin
         q_batt.push_back(b & 12'hFFF);
         if (q_batt.size() == 4) begin
            sum = 0;
            foreach (q_batt[i]) sum += q_batt[i];
            m_avg = sum / 4;
            q_batt.delete();
            if (!m_low && m_avg < THRES) m_low = 1'b1;
            else if (m_low && m_avg >= CLR) m_low = 1'b0;
         end
      end
      if (!pwr_up) begin
         m_streak = 0;
      end else if (sv) begin
         avg = (int'($signed(12'(l))) + int'($signed(12'(r)))) >>> 1;
         mag = (avg < 0) ? -avg : avg;
         if (mag > 2047) mag = 2047;
         if (mag > FTHR) m_streak++;
         else            m_streak = 0;
      end
      #1;
      batt_vld = 1'b0;
      spd_vld  = 1'b0;
      chk_all(tag);
   endtask

   initial begin
      rst_n    = 1'b0;
      batt_vld = 1'b0;
      batt     = '0;
      spd_vld  = 1'b0;
      lft_spd  = '0;
      rght_spd = '0;
      pwr_up   = 1'b0;
      model_reset();
      #22;
      chk_all("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // 1: first average from INIT goes to OK
      for (int i = 0; i < 3; i++) step("t1.pre", 1, 'h900, 0, 0, 0);
      chk("t1.pre_avg", int'(batt_avg), 0);
      step("t1.last", 1, 'h900, 0, 0, 0);
      chk("t1.avg900", int'(batt_avg), 'h900);
      chk("t1.low0", int'(batt_low), 0);

      // 2: hysteresis
      for (int i = 0; i < 4; i++) step("t2.7f0", 1, 'h7F0, 0, 0, 0);
      chk("t2.low_set", int'(batt_low), 1);
      for (int i = 0; i < 4; i++) step("t2.820", 1, 'h820, 0, 0, 0);
      chk("t2.in_band", int'(batt_low), 1);
      for (int i = 0; i < 4; i++) step("t2.840", 1, 'h840, 0, 0, 0);
      chk("t2.low_clr", int'(batt_low), 0);

      // 3: debounce and equality threshold
      pwr_up = 1'b1;
      for (int i = 0; i < 3; i++) step("t3.pre", 0, 0, 1, 1600, 1600);
      chk("t3.not_yet", int'(too_fast), 0);
      step("t3.fourth", 0, 0, 1, 1600, 1600);
      chk("t3.fast", int'(too_fast), 1);
      step("t3.idle", 0, 0, 0, 0, 0);
      chk("t3.hold", int'(too_fast), 1);
      step("t3.eq", 0, 0, 1, 1536, 1536);
      chk("t3.eq_clr", int'(too_fast), 0);

      // 4: broken streak, then saturated negative magnitude
      for (int i = 0; i < 3; i++) step("t4.a", 0, 0, 1, 1600, 1600);
      step("t4.slow", 0, 0, 1, 100, 100);
      for (int i = 0; i < 3; i++) step("t4.b", 0, 0, 1, 1600, 1600);
      chk("t4.never", int'(too_fast), 0);
      step("t4.sep", 0, 0, 1, 100, 100);
      for (int i = 0; i < 4; i++) step("t4.neg", 0, 0, 1, -2048, -2048);
      chk("t4.sat", int'(too_fast), 1);

      // 5: pwr_up low clears, fresh streak needed
      pwr_up = 1'b0;
      step("t5.off", 0, 0, 0, 0, 0);
      chk("t5.off_clr", int'(too_fast), 0);
      pwr_up = 1'b1;
      for (int i = 0; i < 3; i++) step("t5.re", 0, 0, 1, 1600, 1600);
      chk("t5.not_yet", int'(too_fast), 0);
      step("t5.fourth", 0, 0, 1, 1600, 1600);
      chk("t5.fast", int'(too_fast), 1);

      // 6: async reset mid-average while too_fast is set
      step("t6.s1", 1, 'h700, 0, 0, 0);
      step("t6.s2", 1, 'h700, 0, 0, 0);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      chk_all("t6.rst");
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) step("t6.600", 1, 'h600, 0, 0, 0);
      chk("t6.avg600", int'(batt_avg), 'h600);
      chk("t6.init_low", int'(batt_low), 1);

      // randomized: both paths, simultaneous and back-to-back strobes
      for (int i = 0; i < 400; i++) begin
         int b;
         int l;
         int r;
         pwr_up = ($urandom_range(0, 15) != 0);
         b = $urandom_range(12'h7A0, 12'h8A0);
         if ($urandom_range(0, 3) == 0) begin
            l = int'($urandom_range(0, 4095)) - 2048;
            r = int'($urandom_range(0, 4095)) - 2048;
         end else begin
            l = $urandom_range(1480, 1700);
            r = $urandom_range(1480, 1700);
            if ($urandom_range(0, 1) == 1) begin
               l = -l;
               r = -r;
            end
         end
         step("rnd", ($urandom_range(0, 2) != 0), b, ($urandom_range(0, 3) != 0), l, r);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
